// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered EX-stage execution unit.
// Single-cycle ALU ops complete one cycle after acceptance; MUL is a
// 32-step iterative shift-add that holds busy_o high so the pipeline stalls.
module alu_exec_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MUL_STEPS = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [4:0]       shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    localparam int unsigned CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_LUI  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRLV = 4'b1111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_illegal;
    logic             r_done;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic             w_alu_ill;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_acc_next;

    assign w_accept   = (r_state == S_IDLE) && start_i;
    assign w_is_mul   = (ALUCtrl_i == OP_MUL);
    assign w_mul_last = (r_state == S_MUL) && (r_count == CW'(MUL_STEPS - 1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Single-cycle ALU result and flags, decoded from the control code
    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_ill = 1'b0;
        case (ALUCtrl_i)
            OP_AND:  w_alu_res = src1_i & src2_i;
            OP_OR:   w_alu_res = src1_i | src2_i;
            OP_ADD: begin
                w_alu_res = src1_i + src2_i;
                w_alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                            (w_alu_res[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = src1_i - src2_i;
                w_alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                            (w_alu_res[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT:  w_alu_res[0] = ($signed(src1_i) < $signed(src2_i));
            OP_SLL:  w_alu_res = src2_i << shamt_i;
            OP_SRLV: w_alu_res = src2_i >> src1_i[4:0];
            OP_LUI:  w_alu_res = src2_i << 16;
            OP_MUL:  w_alu_res = '0;
            default: w_alu_ill = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: enter MUL on an accepted multiply, leave after the last step
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:  if (w_mul_last)           w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: result/flag registers and the shift-add multiplier
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
            r_done     <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_count    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_result   <= w_alu_res;
                r_zero     <= (w_alu_res == '0);
                r_overflow <= w_alu_ovf;
                r_illegal  <= w_alu_ill;
                r_done     <= 1'b1;
            end
            if (w_accept && w_is_mul) begin
                r_mcand  <= src1_i;
                r_mplier <= src2_i;
                r_acc    <= '0;
                r_count  <= '0;
            end
            if (r_state == S_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CW'(1);
                // The final add is folded in here so the result is ready
                // on the same edge that leaves MUL.
                if (w_mul_last) begin
                    r_result   <= w_acc_next;
                    r_zero     <= (w_acc_next == '0);
                    r_overflow <= 1'b0;
                    r_illegal  <= 1'b0;
                    r_done     <= 1'b1;
                end
            end
        end
    end

    // Outputs: busy tracks the MUL state, the rest come straight from registers
    always_comb begin
        busy_o     = (r_state == S_MUL);
        done_o     = r_done;
        result_o   = r_result;
        zero_o     = r_zero;
        overflow_o = r_overflow;
        illegal_o  = r_illegal;
    end

endmodule
